scoreboard: RTL and testbench
=============================

// Module: scoreboard
//
// PURPOSE
// Owns the register and predicate pending-write state that the decode stage reads.
// Issue events from decode set a pending bit on the destination. Writeback events
// from the short pipeline and from the long-latency MULT/DIV unit clear it.
// The block drives sb2d_reg_scoreboard and sb2d_pred_scoreboard back into decode,
// which uses them for its RAW/WAW dep_stall.
// Flush cancels short-pipeline writers only; long-unit writers survive a flush.
//
// PARAMETERS
// NUM_REGS   32  architectural GPR count; width of sb2d_reg_scoreboard
// NUM_PREDS  3   writable predicates p0..p2; index 3 is constant-true and never tracked
// BYPASS_WB  1   1: same-cycle writeback clears the output bit combinationally; 0: registered only
//
// PORTS
// clk                   in   1   core clock
// rst_n                 in   1   asynchronous active-low reset
// d2sb_issue            in   1   decode hands an instruction to execute this cycle (valid, not stalled)
// d2sb_rd_num           in   5   destination register; predicate index in [1:0]
// d2sb_rd_we            in   1   instruction writes GPR rd_num
// d2sb_pred_we          in   1   instruction writes predicate rd_num[1:0]
// d2sb_long             in   1   writer is the MULT/DIV unit, not the short pipeline
// wb2sb_rd_num          in   5   short-pipeline writeback destination
// wb2sb_rd_we           in   1   short-pipeline GPR writeback this cycle
// wb2sb_pred_we         in   1   short-pipeline predicate writeback this cycle
// lu2sb_rd_num          in   5   long-unit writeback destination
// lu2sb_rd_we           in   1   long-unit GPR writeback this cycle
// flush                 in   1   pipeline kill: cancel all short-owned pending writes
// sb2d_reg_scoreboard   out  32  bit i = GPR i has an outstanding write
// sb2d_pred_scoreboard  out  3   bit i = predicate i has an outstanding write
// sb_err                out  1   sticky protocol-violation flag
//
// BEHAVIOUR
// - State per GPR: pend[i] and long_own[i]. State per predicate: ppend[i] (always short-owned).
// - Reset (async, rst_n=0): every pend, long_own, ppend and sb_err = 0. All outputs read 0.
// - Next-state order within one cycle, per entry:
//   1. Short writeback clears a short-owned entry.
//   2. Long writeback clears a long-owned entry.
//   3. Flush clears every short-owned entry and every ppend.
//   4. Issue sets the entry (when not flushed).
// - Issue (d2sb_issue=1, flush=0):
//   - rd_we sets pend[rd_num]=1 and long_own[rd_num]=d2sb_long.
//   - pred_we with rd_num[1:0]<3 sets ppend[rd_num[1:0]]. Index 3 is ignored.
//   - rd_we and pred_we both set is illegal: sb_err=1, both are applied.
// - Issue while flush=1 is dropped; flush dominates issue.
// - Same-cycle clear and set on one entry: the entry ends set with the new owner.
// - wb2sb_rd_we to a long-owned entry, or lu2sb_rd_we to a short-owned entry: sb_err=1, entry unchanged.
// - Writeback to a non-pending entry: sb_err=1, no state change.
// - Issue to an already-pending entry: sb_err=1 (decode should have stalled), owner overwritten.
// - A long-owned entry persists across flush until lu2sb_rd_we clears it.
// - Outputs:
//   - reg bit = pend.
//   - pred bit = ppend.
//   - If BYPASS_WB=1, additionally masked by a same-cycle legal writeback to that entry.
//   - Issue-side sets are never bypassed: visible exactly 1 cycle after the issue.
// - Latency:
//   - Issue at cycle t: stall bit visible at t+1.
//   - Writeback at t: bit clear at t (BYPASS_WB=1) or at t+1 (BYPASS_WB=0).
// - Simultaneous wb2sb and lu2sb to the same register: each checks its own owner rule; only the legal one clears.
// - sb_err remains 1 until rst_n.
//
// TESTING
// - Reset mid-run with pend[5], ppend[1] and sb_err set -> all outputs 0 during rst_n low and after release.
// - Issue rd=7 at t, wb2sb rd=7 at t+3 -> reg bit7 is 0 at t, 1 at t+1..t+2, 0 at t+3 (BYPASS_WB=1) or t+4 (BYPASS_WB=0); sb_err=0.
// - Issue rd=9 long, issue rd=4 short, then flush -> bit4=0 and bit9=1 after flush; lu2sb rd=9 two cycles later -> bit9=0.
// - Same cycle: wb2sb clears r3 and issue sets r3 -> bit3 stays 1 next cycle, sb_err=0.
// - Issue pred_we rd_num=2 -> pred bit2=1; pred_we rd_num=3 -> pred scoreboard unchanged; wb2sb_pred_we rd_num=2 -> bit2 clears.
// - wb2sb_rd_we to idle r12 -> sb_err=1, sticky for 100 cycles; lu2sb to short-owned r6 -> bit6 unchanged.

Source files
------------

// File: rtl/scoreboard.sv
// ---------------------------------------------------------------------------
// scoreboard
//
// Tracks outstanding writes to GPRs and writable predicates so decode can
// stall on RAW/WAW hazards. Decode issue sets a pending bit on the
// destination. Short-pipeline or long-unit (MULT/DIV) writebacks clear it.
// Each GPR remembers which unit owns its pending write. A flush cancels
// short-owned writes only.
//
// Ports
//   clk, rst_n                     core clock, async active-low reset
//   d2sb_issue/rd_num/rd_we/
//   d2sb_pred_we/d2sb_long         issue event from decode
//   wb2sb_rd_num/rd_we/pred_we     short-pipeline writeback
//   lu2sb_rd_num/rd_we             long-unit writeback
//   flush                          kill all short-owned pending writes
//   sb2d_reg_scoreboard            per-GPR pending flags to decode
//   sb2d_pred_scoreboard           per-predicate pending flags to decode
//   sb_err                         sticky protocol-violation flag
// ---------------------------------------------------------------------------
module scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int NUM_PREDS = 3,
  parameter int BYPASS_WB = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 d2sb_issue,
  input  logic [4:0]           d2sb_rd_num,
  input  logic                 d2sb_rd_we,
  input  logic                 d2sb_pred_we,
  input  logic                 d2sb_long,
  input  logic [4:0]           wb2sb_rd_num,
  input  logic                 wb2sb_rd_we,
  input  logic                 wb2sb_pred_we,
  input  logic [4:0]           lu2sb_rd_num,
  input  logic                 lu2sb_rd_we,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  sb2d_reg_scoreboard,
  output logic [NUM_PREDS-1:0] sb2d_pred_scoreboard,
  output logic                 sb_err
);

  localparam bit BYP = (BYPASS_WB != 0);

  logic [NUM_REGS-1:0]  pend;
  logic [NUM_REGS-1:0]  long_own;
  logic [NUM_PREDS-1:0] ppend;

  logic                 issue_ok;
  logic [NUM_REGS-1:0]  sw_sel, lw_sel, is_sel;
  logic [NUM_REGS-1:0]  sw_ok, lw_ok;
  logic [NUM_REGS-1:0]  pend_kept, pend_nxt, long_nxt;
  logic [NUM_PREDS-1:0] pwb_sel, pis_sel, pwb_ok;
  logic [NUM_PREDS-1:0] ppend_kept, ppend_nxt;
  logic                 err_nxt;

  // Flush dominates issue: a killed instruction never reaches the scoreboard.
  assign issue_ok = d2sb_issue & ~flush;

  // One-hot selects. Predicate index 3 (constant-true) shifts out of the
  // NUM_PREDS-wide vector, so it is never tracked.
  assign sw_sel  = {{(NUM_REGS-1){1'b0}}, wb2sb_rd_we} << wb2sb_rd_num;
  assign lw_sel  = {{(NUM_REGS-1){1'b0}}, lu2sb_rd_we} << lu2sb_rd_num;
  assign is_sel  = {{(NUM_REGS-1){1'b0}}, (issue_ok & d2sb_rd_we)} << d2sb_rd_num;
  assign pwb_sel = {{(NUM_PREDS-1){1'b0}}, wb2sb_pred_we} << wb2sb_rd_num[1:0];
  assign pis_sel = {{(NUM_PREDS-1){1'b0}}, (issue_ok & d2sb_pred_we)} << d2sb_rd_num[1:0];

  // A writeback is legal only when it hits a pending entry its own unit owns.
  assign sw_ok  = sw_sel & pend & ~long_own;
  assign lw_ok  = lw_sel & pend & long_own;
  assign pwb_ok = pwb_sel & ppend;

  always_comb begin
    pend_kept  = pend & ~sw_ok & ~lw_ok;
    ppend_kept = ppend & ~pwb_ok;
    if (flush) begin
      pend_kept  = pend_kept & long_own;
      ppend_kept = '0;
    end
    // Issue wins over a same-cycle clear and takes the new owner.
    pend_nxt  = pend_kept | is_sel;
    long_nxt  = (long_own & pend_kept & ~is_sel) | (is_sel & {NUM_REGS{d2sb_long}});
    ppend_nxt = ppend_kept | pis_sel;
    // Issue to an entry still pending after this cycle's clears means decode
    // failed to stall.
    err_nxt = sb_err
            | (|(sw_sel & ~(pend & ~long_own)))
            | (|(lw_sel & ~(pend & long_own)))
            | (|(pwb_sel & ~ppend))
            | (issue_ok & d2sb_rd_we & d2sb_pred_we)
            | (|(is_sel & pend_kept))
            | (|(pis_sel & ppend_kept));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      long_own <= '0;
      ppend    <= '0;
      sb_err   <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      long_own <= long_nxt;
      ppend    <= ppend_nxt;
      sb_err   <= err_nxt;
    end
  end

  // Legal writebacks release the stall in the same cycle when bypassing.
  // Issue-side sets always appear one cycle later.
  assign sb2d_reg_scoreboard  = BYP ? (pend & ~(sw_ok | lw_ok)) : pend;
  assign sb2d_pred_scoreboard = BYP ? (ppend & ~pwb_ok) : ppend;

endmodule

// File: tb/tb_scoreboard.sv
module tb_scoreboard;

  localparam bit BYP = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        d2sb_issue, d2sb_rd_we, d2sb_pred_we, d2sb_long;
  logic [4:0]  d2sb_rd_num;
  logic [4:0]  wb2sb_rd_num;
  logic        wb2sb_rd_we, wb2sb_pred_we;
  logic [4:0]  lu2sb_rd_num;
  logic        lu2sb_rd_we;
  logic        flush;
  logic [31:0] sb2d_reg_scoreboard;
  logic [2:0]  sb2d_pred_scoreboard;
  logic        sb_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] obs_reg;
  logic [2:0]  obs_pred;
  logic        obs_err;

  // Reference state: which registers/predicates wait on a write, and who owns it.
  bit m_pend [32];
  bit m_long [32];
  bit m_ppend[3];
  bit m_err;

  scoreboard #(.NUM_REGS(32), .NUM_PREDS(3), .BYPASS_WB(1)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .d2sb_issue          (d2sb_issue),
    .d2sb_rd_num         (d2sb_rd_num),
    .d2sb_rd_we          (d2sb_rd_we),
    .d2sb_pred_we        (d2sb_pred_we),
    .d2sb_long           (d2sb_long),
    .wb2sb_rd_num        (wb2sb_rd_num),
    .wb2sb_rd_we         (wb2sb_rd_we),
    .wb2sb_pred_we       (wb2sb_pred_we),
    .lu2sb_rd_num        (lu2sb_rd_num),
    .lu2sb_rd_we         (lu2sb_rd_we),
    .flush               (flush),
    .sb2d_reg_scoreboard (sb2d_reg_scoreboard),
    .sb2d_pred_scoreboard(sb2d_pred_scoreboard),
    .sb_err              (sb_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_pend[i] = 1'b0;
      m_long[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) m_ppend[i] = 1'b0;
    m_err = 1'b0;
  endfunction

  // Expected outputs for the current cycle: pending flags, minus any entry a
  // legal writeback is retiring right now when bypass is enabled.
  function automatic void model_out(output logic [31:0] er, output logic [2:0] ep);
    for (int i = 0; i < 32; i++) begin
      bit retiring;
      retiring = 1'b0;
      if (BYP && m_pend[i]) begin
        if (wb2sb_rd_we && int'(wb2sb_rd_num) == i && !m_long[i]) retiring = 1'b1;
        if (lu2sb_rd_we && int'(lu2sb_rd_num) == i && m_long[i])  retiring = 1'b1;
      end
      er[i] = m_pend[i] && !retiring;
    end
    for (int p = 0; p < 3; p++) begin
      bit retiring;
      retiring = BYP && m_ppend[p] && wb2sb_pred_we && int'(wb2sb_rd_num[1:0]) == p;
      ep[p] = m_ppend[p] && !retiring;
    end
  endfunction

  // Apply one clock edge of the scoreboard rules to the reference state.
  function automatic void model_step();
    int w, l, d, wp, dp;
    bit sw_clear, lw_clear, pw_clear;
    w  = int'(wb2sb_rd_num);
    l  = int'(lu2sb_rd_num);
    d  = int'(d2sb_rd_num);
    wp = int'(wb2sb_rd_num[1:0]);
    dp = int'(d2sb_rd_num[1:0]);
    sw_clear = 1'b0;
    lw_clear = 1'b0;
    pw_clear = 1'b0;
    // Both writeback checks look at the state from before this edge.
    if (wb2sb_rd_we) begin
      if (m_pend[w] && !m_long[w]) sw_clear = 1'b1;
      else m_err = 1'b1;
    end
    if (lu2sb_rd_we) begin
      if (m_pend[l] && m_long[l]) lw_clear = 1'b1;
      else m_err = 1'b1;
    end
    if (wb2sb_pred_we && wp < 3) begin
      if (m_ppend[wp]) pw_clear = 1'b1;
      else m_err = 1'b1;
    end
    if (sw_clear) m_pend[w] = 1'b0;
    if (lw_clear) m_pend[l] = 1'b0;
    if (pw_clear) m_ppend[wp] = 1'b0;
    if (flush) begin
      for (int i = 0; i < 32; i++) if (!m_long[i]) m_pend[i] = 1'b0;
      for (int p = 0; p < 3; p++) m_ppend[p] = 1'b0;
    end else if (d2sb_issue) begin
      if (d2sb_rd_we && d2sb_pred_we) m_err = 1'b1;
      if (d2sb_rd_we) begin
        if (m_pend[d]) m_err = 1'b1;
        m_pend[d] = 1'b1;
        m_long[d] = d2sb_long;
      end
      if (d2sb_pred_we && dp < 3) begin
        if (m_ppend[dp]) m_err = 1'b1;
        m_ppend[dp] = 1'b1;
      end
    end
  endfunction

  task automatic idle_inputs();
    d2sb_issue    = 1'b0;
    d2sb_rd_num   = 5'd0;
    d2sb_rd_we    = 1'b0;
    d2sb_pred_we  = 1'b0;
    d2sb_long     = 1'b0;
    wb2sb_rd_num  = 5'd0;
    wb2sb_rd_we   = 1'b0;
    wb2sb_pred_we = 1'b0;
    lu2sb_rd_num  = 5'd0;
    lu2sb_rd_we   = 1'b0;
    flush         = 1'b0;
  endtask

  // One cycle with the currently driven inputs: sample on the falling edge,
  // compare against the model, then advance the model on the rising edge.
  task automatic tick(input string tag);
    logic [31:0] er;
    logic [2:0]  ep;
    @(negedge clk);
    model_out(er, ep);
    obs_reg  = sb2d_reg_scoreboard;
    obs_pred = sb2d_pred_scoreboard;
    obs_err  = sb_err;
    total++;
    if (obs_reg !== er) begin
      bad++;
      $display("FAIL %s reg_sb: got %h want %h", tag, obs_reg, er);
    end
    total++;
    if (obs_pred !== ep) begin
      bad++;
      $display("FAIL %s pred_sb: got %b want %b", tag, obs_pred, ep);
    end
    total++;
    if (obs_err !== m_err) begin
      bad++;
      $display("FAIL %s sb_err: got %b want %b", tag, obs_err, m_err);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    total++;
    if ({sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb_err} !== 36'd0) begin
      bad++;
      $display("FAIL reset_low: got %h/%b/%b want 0", sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb_err);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick("reset_release");
  endtask

  task automatic test_raw_latency();
    idle_inputs();
    d2sb_issue = 1'b1; d2sb_rd_we = 1'b1; d2sb_rd_num = 5'd7;
    tick("raw_t0");
    total++;
    if (obs_reg[7] !== 1'b0) begin bad++; $display("FAIL raw_t0 bit7: got %b want 0", obs_reg[7]); end
    idle_inputs();
    for (int k = 1; k <= 2; k++) begin
      tick("raw_wait");
      total++;
      if (obs_reg[7] !== 1'b1) begin bad++; $display("FAIL raw_t%0d bit7: got %b want 1", k, obs_reg[7]); end
    end
    wb2sb_rd_we = 1'b1; wb2sb_rd_num = 5'd7;
    tick("raw_t3");
    total++;
    if (obs_reg[7] !== 1'b0) begin bad++; $display("FAIL raw_t3 bit7: got %b want 0", obs_reg[7]); end
    idle_inputs();
    tick("raw_t4");
    total++;
    if (obs_reg[7] !== 1'b0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL raw_t4 bit7/err: got %b/%b want 0/0", obs_reg[7], obs_err);
    end
  endtask

  task automatic test_flush_long();
    idle_inputs();
    d2sb_issue = 1'b1; d2sb_rd_we = 1'b1; d2sb_rd_num = 5'd9; d2sb_long = 1'b1;
    tick("fl_issue9");
    d2sb_rd_num = 5'd4; d2sb_long = 1'b0;
    tick("fl_issue4");
    idle_inputs();
    flush = 1'b1;
    tick("fl_flush");
    flush = 1'b0;
    tick("fl_after");
    total++;
    if (obs_reg[4] !== 1'b0 || obs_reg[9] !== 1'b1) begin
      bad++; $display("FAIL flush_keep_long bit4/bit9: got %b/%b want 0/1", obs_reg[4], obs_reg[9]);
    end
    tick("fl_gap");
    lu2sb_rd_we = 1'b1; lu2sb_rd_num = 5'd9;
    tick("fl_lu9");
    idle_inputs();
    tick("fl_done");
    total++;
    if (obs_reg[9] !== 1'b0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL long_wb bit9/err: got %b/%b want 0/0", obs_reg[9], obs_err);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    d2sb_issue = 1'b1; d2sb_rd_we = 1'b1; d2sb_rd_num = 5'd3;
    tick("b2b_issue");
    idle_inputs();
    tick("b2b_wait");
    d2sb_issue = 1'b1; d2sb_rd_we = 1'b1; d2sb_rd_num = 5'd3;
    wb2sb_rd_we = 1'b1; wb2sb_rd_num = 5'd3;
    tick("b2b_same");
    idle_inputs();
    tick("b2b_next");
    total++;
    if (obs_reg[3] !== 1'b1 || obs_err !== 1'b0) begin
      bad++; $display("FAIL clear_and_set bit3/err: got %b/%b want 1/0", obs_reg[3], obs_err);
    end
    wb2sb_rd_we = 1'b1; wb2sb_rd_num = 5'd3;
    tick("b2b_clean");
    idle_inputs();
  endtask

  task automatic test_pred();
    idle_inputs();
    d2sb_issue = 1'b1; d2sb_pred_we = 1'b1; d2sb_rd_num = 5'd2;
    tick("pred_issue2");
    idle_inputs();
    tick("pred_wait");
    total++;
    if (obs_pred !== 3'b100) begin bad++; $display("FAIL pred_set2: got %b want 100", obs_pred); end
    d2sb_issue = 1'b1; d2sb_pred_we = 1'b1; d2sb_rd_num = 5'd3;
    tick("pred_issue3");
    idle_inputs();
    tick("pred_wait3");
    total++;
    if (obs_pred !== 3'b100 || obs_err !== 1'b0) begin
      bad++; $display("FAIL pred_idx3_ignored pred/err: got %b/%b want 100/0", obs_pred, obs_err);
    end
    wb2sb_pred_we = 1'b1; wb2sb_rd_num = 5'd2;
    tick("pred_wb2");
    total++;
    if (obs_pred !== 3'b000) begin bad++; $display("FAIL pred_bypass: got %b want 000", obs_pred); end
    idle_inputs();
    tick("pred_done");
    total++;
    if (obs_pred !== 3'b000) begin bad++; $display("FAIL pred_clear: got %b want 000", obs_pred); end
  endtask

  task automatic test_errors();
    int misses;
    idle_inputs();
    wb2sb_rd_we = 1'b1; wb2sb_rd_num = 5'd12;
    tick("err_idle_wb");
    idle_inputs();
    misses = 0;
    for (int k = 0; k < 100; k++) begin
      tick("err_sticky");
      if (obs_err !== 1'b1) misses++;
    end
    total++;
    if (misses !== 0) begin bad++; $display("FAIL err_sticky: got %0d low cycles want 0", misses); end
    d2sb_issue = 1'b1; d2sb_rd_we = 1'b1; d2sb_rd_num = 5'd6;
    tick("err_issue6");
    idle_inputs();
    tick("err_wait6");
    lu2sb_rd_we = 1'b1; lu2sb_rd_num = 5'd6;
    tick("err_lu6");
    total++;
    if (obs_reg[6] !== 1'b1) begin bad++; $display("FAIL lu_on_short bypass bit6: got %b want 1", obs_reg[6]); end
    idle_inputs();
    tick("err_after6");
    total++;
    if (obs_reg[6] !== 1'b1) begin bad++; $display("FAIL lu_on_short bit6: got %b want 1", obs_reg[6]); end
  endtask

  task automatic test_midrun_reset();
    idle_inputs();
    d2sb_issue = 1'b1; d2sb_rd_we = 1'b1; d2sb_rd_num = 5'd5;
    tick("mr_issue5");
    d2sb_rd_we = 1'b0; d2sb_pred_we = 1'b1; d2sb_rd_num = 5'd1;
    tick("mr_issue_p1");
    idle_inputs();
    wb2sb_rd_we = 1'b1; wb2sb_rd_num = 5'd12;
    tick("mr_bad_wb");
    idle_inputs();
    tick("mr_loaded");
    total++;
    if (obs_reg[5] !== 1'b1 || obs_pred[1] !== 1'b1 || obs_err !== 1'b1) begin
      bad++; $display("FAIL midrun_preload r5/p1/err: got %b/%b/%b want 1/1/1", obs_reg[5], obs_pred[1], obs_err);
    end
    rst_n = 1'b0;
    model_reset();
    #2;
    total++;
    if ({sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb_err} !== 36'd0) begin
      bad++; $display("FAIL midrun_async: got %h/%b/%b want 0", sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb_err);
    end
    @(negedge clk);
    total++;
    if ({sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb_err} !== 36'd0) begin
      bad++; $display("FAIL midrun_held: got %h/%b/%b want 0", sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb_err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick("mr_release");
    total++;
    if ({obs_reg, obs_pred, obs_err} !== 36'd0) begin
      bad++; $display("FAIL midrun_release: got %h/%b/%b want 0", obs_reg, obs_pred, obs_err);
    end
  endtask

  // Mostly-legal random traffic: issues favour free registers and writebacks
  // target entries the model knows are pending, with occasional violations.
  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      int q[$];
      int r;
      idle_inputs();
      if ($urandom_range(0, 99) < 50) begin
        q = {};
        for (int i = 0; i < 32; i++) if (!m_pend[i]) q.push_back(i);
        d2sb_issue = 1'b1;
        if (q.size() > 0 && $urandom_range(0, 99) < 95)
          d2sb_rd_num = 5'(q[$urandom_range(0, q.size() - 1)]);
        else
          d2sb_rd_num = 5'($urandom_range(0, 31));
        r = $urandom_range(0, 99);
        d2sb_rd_we   = (r < 75);
        d2sb_pred_we = (r >= 73);
        d2sb_long    = ($urandom_range(0, 99) < 30);
      end
      r = $urandom_range(0, 99);
      if (r < 40) begin
        q = {};
        for (int i = 0; i < 32; i++) if (m_pend[i] && !m_long[i]) q.push_back(i);
        if (q.size() > 0) begin
          wb2sb_rd_we  = 1'b1;
          wb2sb_rd_num = 5'(q[$urandom_range(0, q.size() - 1)]);
        end
      end else if (r < 60) begin
        q = {};
        for (int p = 0; p < 3; p++) if (m_ppend[p]) q.push_back(p);
        if (q.size() > 0) begin
          wb2sb_pred_we = 1'b1;
          wb2sb_rd_num  = 5'(q[$urandom_range(0, q.size() - 1)]);
        end
      end else if (r < 63) begin
        wb2sb_rd_we  = 1'b1;
        wb2sb_rd_num = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 99) < 35) begin
        q = {};
        for (int i = 0; i < 32; i++) if (m_pend[i] && m_long[i]) q.push_back(i);
        if (q.size() > 0) begin
          lu2sb_rd_we  = 1'b1;
          lu2sb_rd_num = 5'(q[$urandom_range(0, q.size() - 1)]);
        end
      end
      flush = ($urandom_range(0, 99) < 4);
      tick("random");
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_raw_latency();
    test_flush_long();
    test_back_to_back();
    test_pred();
    total++;
    if (obs_err !== 1'b0) begin bad++; $display("FAIL legal_traffic_err: got %b want 0", obs_err); end
    test_errors();
    test_midrun_reset();
    test_random(400);
    apply_reset();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
